// File: rtl/vga_mem_pkg.sv
// Shared definitions for the video SRAM arbiter.
// Holds the default bus widths, the starvation threshold, the active-low
// SRAM strobe levels and the per-cycle grant encoding used by every stage.
// No ports (package).
package vga_mem_pkg;

   localparam int ADDR_W_DEF   = 15;
   localparam int DATA_W_DEF   = 8;
   localparam int MAX_WAIT_DEF = 800;

   // All SRAM control strobes are active-low.
   localparam logic ACTIVE   = 1'b0;
   localparam logic INACTIVE = 1'b1;

   typedef enum logic [1:0] {
      GNT_NONE   = 2'b00,
      GNT_VID    = 2'b01,
      GNT_CPU_RD = 2'b10,
      GNT_CPU_WR = 2'b11
   } grant_e;

   function automatic logic is_cpu_grant(input grant_e g);
      return (g == GNT_CPU_RD) || (g == GNT_CPU_WR);
   endfunction

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// Bundle of every signal the arbiter exchanges with the scanout logic,
// the CPU/drawing port and the external SRAM pins.
// Modports:
//   slave  - the arbiter: takes requests and SRAM read data, drives
//            video/CPU results and the SRAM address/data/strobes.
//   master - the surroundings (scanout, CPU, SRAM): the mirror image.
interface vga_mem_arbiter_if
   import vga_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              vidReq;
   logic [ADDR_W-1:0] vidAddr;
   logic [DATA_W-1:0] vidData;
   logic              vidValid;

   logic              cpuReq;
   logic              cpuWe;
   logic [ADDR_W-1:0] cpuAddr;
   logic [DATA_W-1:0] cpuWData;
   logic              cpuAck;
   logic [DATA_W-1:0] cpuRData;
   logic              cpuStarvedClr;
   logic              cpuStarved;

   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWData;
   logic              memDataOe;
   logic [DATA_W-1:0] memRData;
   logic              memCe_n;
   logic              memOe_n;
   logic              memWe_n;

   modport slave (
      input  vidReq, vidAddr, cpuReq, cpuWe, cpuAddr, cpuWData,
             cpuStarvedClr, memRData,
      output vidData, vidValid, cpuAck, cpuRData, cpuStarved,
             memAddr, memWData, memDataOe, memCe_n, memOe_n, memWe_n
   );

   modport master (
      output vidReq, vidAddr, cpuReq, cpuWe, cpuAddr, cpuWData,
             cpuStarvedClr, memRData,
      input  vidData, vidValid, cpuAck, cpuRData, cpuStarved,
             memAddr, memWData, memDataOe, memCe_n, memOe_n, memWe_n
   );

endinterface

// File: rtl/vga_mem_wait_counter.sv
// Tracks how long a pending CPU request has been locked out by scanout.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   cpu_req       - CPU request level
//   cpu_inflight  - a CPU access is already outstanding
//   cpu_grant     - the CPU wins arbitration this cycle
//   starved_clr   - clears the sticky starvation flag
//   starved       - sticky flag, set once the wait reaches MAX_WAIT
module vga_mem_wait_counter
   import vga_mem_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cpu_req,
   input  logic cpu_inflight,
   input  logic cpu_grant,
   input  logic starved_clr,
   output logic starved
);

   localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] count_q, count_d;
   logic              starved_q, starved_d;

   // A cycle counts as lost only when the CPU is asking, has nothing
   // outstanding and still was not granted. The flag is set from the next
   // count value so the set lands on the same edge the limit is reached,
   // and a set beats a coincident clear.
   always_comb begin
      count_d   = count_q;
      starved_d = starved_q;
      if (!cpu_req || cpu_grant) begin
         count_d = '0;
      end else if (!cpu_inflight && (count_q != WAIT_MAX)) begin
         count_d = count_q + 1'b1;
      end
      if (count_d == WAIT_MAX) begin
         starved_d = 1'b1;
      end else if (starved_clr) begin
         starved_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         starved_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         starved_q <= starved_d;
      end
   end

   assign starved = starved_q;

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares one asynchronous video SRAM between scanout fetch and a CPU port.
// Three stages: grant (combinational), SRAM access (registered pins),
// capture (registered read data and completion pulses). Scanout always
// wins and sees a fixed 2-cycle latency; the CPU uses the leftover cycles.
// Ports:
//   vgaClock - pixel clock, all logic on the rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - scanout, CPU and SRAM signals (slave modport)
module vga_mem_arbiter
   import vga_mem_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input logic              vgaClock,
   input logic              reset_n,
   vga_mem_arbiter_if.slave bus
);

   grant_e            gnt_d, gnt_q;
   logic              inflight_d, inflight_q;
   logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
   logic              mem_ce_n_d, mem_ce_n_q;
   logic              mem_oe_n_d, mem_oe_n_q;
   logic              mem_we_n_d, mem_we_n_q;
   logic              mem_data_oe_d, mem_data_oe_q;
   logic [DATA_W-1:0] vid_data_d, vid_data_q;
   logic              vid_valid_d, vid_valid_q;
   logic [DATA_W-1:0] cpu_rdata_d, cpu_rdata_q;
   logic              cpu_ack_d, cpu_ack_q;

   // Grant, SRAM pin values for the next cycle and capture of the access
   // granted last cycle. The in-flight flag stays set through the ack
   // cycle so a cpuReq still held there is not granted a second time.
   always_comb begin
      gnt_d         = GNT_NONE;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_ce_n_d    = INACTIVE;
      mem_oe_n_d    = INACTIVE;
      mem_we_n_d    = INACTIVE;
      mem_data_oe_d = 1'b0;
      vid_data_d    = vid_data_q;
      vid_valid_d   = 1'b0;
      cpu_rdata_d   = cpu_rdata_q;
      cpu_ack_d     = 1'b0;
      inflight_d    = inflight_q;

      if (bus.vidReq) begin
         gnt_d = GNT_VID;
      end else if (bus.cpuReq && !inflight_q) begin
         gnt_d = bus.cpuWe ? GNT_CPU_WR : GNT_CPU_RD;
      end

      case (gnt_d)
         GNT_VID: begin
            mem_addr_d = bus.vidAddr;
            mem_ce_n_d = ACTIVE;
            mem_oe_n_d = ACTIVE;
         end
         GNT_CPU_RD: begin
            mem_addr_d = bus.cpuAddr;
            mem_ce_n_d = ACTIVE;
            mem_oe_n_d = ACTIVE;
         end
         GNT_CPU_WR: begin
            mem_addr_d    = bus.cpuAddr;
            mem_wdata_d   = bus.cpuWData;
            mem_ce_n_d    = ACTIVE;
            mem_we_n_d    = ACTIVE;
            mem_data_oe_d = 1'b1;
         end
         default: ;
      endcase

      if (gnt_q == GNT_VID) begin
         vid_valid_d = 1'b1;
         vid_data_d  = bus.memRData;
      end
      if (is_cpu_grant(gnt_q)) begin
         cpu_ack_d = 1'b1;
      end
      if (gnt_q == GNT_CPU_RD) begin
         cpu_rdata_d = bus.memRData;
      end

      if (is_cpu_grant(gnt_d)) begin
         inflight_d = 1'b1;
      end else if (cpu_ack_q) begin
         inflight_d = 1'b0;
      end
   end

   always_ff @(posedge vgaClock or negedge reset_n) begin
      if (!reset_n) begin
         gnt_q         <= GNT_NONE;
         inflight_q    <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_ce_n_q    <= INACTIVE;
         mem_oe_n_q    <= INACTIVE;
         mem_we_n_q    <= INACTIVE;
         mem_data_oe_q <= 1'b0;
         vid_data_q    <= '0;
         vid_valid_q   <= 1'b0;
         cpu_rdata_q   <= '0;
         cpu_ack_q     <= 1'b0;
      end else begin
         gnt_q         <= gnt_d;
         inflight_q    <= inflight_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_ce_n_q    <= mem_ce_n_d;
         mem_oe_n_q    <= mem_oe_n_d;
         mem_we_n_q    <= mem_we_n_d;
         mem_data_oe_q <= mem_data_oe_d;
         vid_data_q    <= vid_data_d;
         vid_valid_q   <= vid_valid_d;
         cpu_rdata_q   <= cpu_rdata_d;
         cpu_ack_q     <= cpu_ack_d;
      end
   end

   vga_mem_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_counter (
      .clk          (vgaClock),
      .rst_n        (reset_n),
      .cpu_req      (bus.cpuReq),
      .cpu_inflight (inflight_q),
      .cpu_grant    (is_cpu_grant(gnt_d)),
      .starved_clr  (bus.cpuStarvedClr),
      .starved      (bus.cpuStarved)
   );

   assign bus.memAddr   = mem_addr_q;
   assign bus.memWData  = mem_wdata_q;
   assign bus.memCe_n   = mem_ce_n_q;
   assign bus.memOe_n   = mem_oe_n_q;
   assign bus.memWe_n   = mem_we_n_q;
   assign bus.memDataOe = mem_data_oe_q;
   assign bus.vidData   = vid_data_q;
   assign bus.vidValid  = vid_valid_q;
   assign bus.cpuRData  = cpu_rdata_q;
   assign bus.cpuAck    = cpu_ack_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: table of single transactions,
// then collision, starvation and reset-abort sequences. Completions are
// checked by a scoreboard of expected (cycle, data) records.
module tb_vga_mem_arbiter;

   logic vgaClock = 1'b0;
   logic reset_n  = 1'b0;
   int   cyc      = 0;
   int   nChecks  = 0;
   int   nPass    = 0;

   typedef struct {
      logic        isVid;
      logic        we;
      logic [14:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  expData;
   } vec_t;

   typedef struct {
      int         due;
      logic       chk;
      logic [7:0] data;
   } exp_t;

   exp_t vidQ[$];
   exp_t cpuQ[$];
   vec_t vecs[9];

   vga_mem_arbiter_if #(.ADDR_W(15), .DATA_W(8)) bus ();

   vga_mem_arbiter dut (
      .vgaClock (vgaClock),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   // Pixel clock and a cycle index that advances on every rising edge.
   always #5 vgaClock = ~vgaClock;
   always @(posedge vgaClock) cyc <= cyc + 1;

   // Asynchronous SRAM model: combinational read, write at the end of a
   // cycle with WE low. One location is preloaded for the video tests.
   logic [7:0] sram [0:32767];
   logic       sramLoaded = 1'b0;
   assign bus.memRData = (!bus.memCe_n && !bus.memOe_n) ? sram[bus.memAddr] : 8'h00;
   always @(posedge vgaClock) begin
      if (!sramLoaded) begin
         sram[15'h0123] <= 8'hA5;
         sramLoaded     <= 1'b1;
      end else if (!bus.memCe_n && !bus.memWe_n && bus.memDataOe) begin
         sram[bus.memAddr] <= bus.memWData;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual === expected) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge vgaClock);
      #1;
   endtask

   task automatic pushVid(input int due, input logic [7:0] data);
      vidQ.push_back('{due, 1'b1, data});
   endtask

   task automatic pushCpu(input int due, input logic chk, input logic [7:0] data);
      cpuQ.push_back('{due, chk, data});
   endtask

   // Hold cpuReq until the ack shows up, then drop it the cycle after.
   task automatic waitCpuAckAndDrop();
      int n = 0;
      while (!bus.cpuAck && n < 8) begin
         tick();
         n++;
      end
      if (n == 8) checkOutput("cpuAck wait", 32'(bus.cpuAck), 32'(1));
      tick();
      bus.cpuReq = 1'b0;
   endtask

   // Scoreboard: completions are compared against queued expectations on
   // the falling edge; a missing one at its due cycle is a failure.
   always @(negedge vgaClock) begin : monitor
      exp_t e;
      if (bus.vidValid) begin
         if (vidQ.size() == 0) checkOutput("vidValid spurious", 32'(bus.vidValid), 32'(0));
         else begin
            e = vidQ.pop_front();
            checkOutput("vidValid cycle", 32'(cyc), 32'(e.due));
            checkOutput("vidData", 32'(bus.vidData), 32'(e.data));
         end
      end else if (vidQ.size() != 0 && vidQ[0].due <= cyc) begin
         e = vidQ.pop_front();
         checkOutput("vidValid missing", 32'(bus.vidValid), 32'(1));
      end
      if (bus.cpuAck) begin
         if (cpuQ.size() == 0) checkOutput("cpuAck spurious", 32'(bus.cpuAck), 32'(0));
         else begin
            e = cpuQ.pop_front();
            checkOutput("cpuAck cycle", 32'(cyc), 32'(e.due));
            if (e.chk) checkOutput("cpuRData", 32'(bus.cpuRData), 32'(e.data));
         end
      end else if (cpuQ.size() != 0 && cpuQ[0].due <= cyc) begin
         e = cpuQ.pop_front();
         checkOutput("cpuAck missing", 32'(bus.cpuAck), 32'(1));
      end
   end

   // One isolated transaction: checks the SRAM pins in the access cycle
   // and queues the completion expected two cycles after the grant.
   task automatic applyStimulus(input vec_t v);
      if (v.isVid) begin
         bus.vidReq  = 1'b1;
         bus.vidAddr = v.addr;
         pushVid(cyc + 2, v.expData);
         tick();
         bus.vidReq = 1'b0;
         checkOutput("vid memAddr", 32'(bus.memAddr), 32'(v.addr));
         checkOutput("vid memCe_n", 32'(bus.memCe_n), 32'(0));
         checkOutput("vid memOe_n", 32'(bus.memOe_n), 32'(0));
         checkOutput("vid memWe_n", 32'(bus.memWe_n), 32'(1));
         checkOutput("vid memDataOe", 32'(bus.memDataOe), 32'(0));
         tick();
         tick();
      end else begin
         bus.cpuReq   = 1'b1;
         bus.cpuWe    = v.we;
         bus.cpuAddr  = v.addr;
         bus.cpuWData = v.wdata;
         pushCpu(cyc + 2, !v.we, v.expData);
         tick();
         checkOutput("cpu memAddr", 32'(bus.memAddr), 32'(v.addr));
         checkOutput("cpu memCe_n", 32'(bus.memCe_n), 32'(0));
         checkOutput("cpu memOe_n", 32'(bus.memOe_n), 32'(v.we));
         checkOutput("cpu memWe_n", 32'(bus.memWe_n), 32'(!v.we));
         checkOutput("cpu memDataOe", 32'(bus.memDataOe), 32'(v.we));
         if (v.we) checkOutput("cpu memWData", 32'(bus.memWData), 32'(v.wdata));
         tick();
         checkOutput("cpu no regrant memCe_n", 32'(bus.memCe_n), 32'(1));
         checkOutput("cpu memWe_n released", 32'(bus.memWe_n), 32'(1));
         waitCpuAckAndDrop();
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b1, 15'h7FFF, 8'h3C, 8'h00};
      vecs[1] = '{1'b0, 1'b0, 15'h7FFF, 8'h00, 8'h3C};
      vecs[2] = '{1'b1, 1'b0, 15'h0123, 8'h00, 8'hA5};
      vecs[3] = '{1'b0, 1'b1, 15'h0000, 8'h5A, 8'h00};
      vecs[4] = '{1'b1, 1'b0, 15'h0000, 8'h00, 8'h5A};
      vecs[5] = '{1'b0, 1'b0, 15'h0123, 8'h00, 8'hA5};
      vecs[6] = '{1'b0, 1'b1, 15'h1234, 8'hC3, 8'h00};
      vecs[7] = '{1'b0, 1'b0, 15'h1234, 8'h00, 8'hC3};
      vecs[8] = '{1'b1, 1'b0, 15'h7FFF, 8'h00, 8'h3C};

      bus.vidReq        = 1'b0;
      bus.vidAddr       = '0;
      bus.cpuReq        = 1'b0;
      bus.cpuWe         = 1'b0;
      bus.cpuAddr       = '0;
      bus.cpuWData      = '0;
      bus.cpuStarvedClr = 1'b0;

      // Reset values.
      tick();
      tick();
      checkOutput("reset memCe_n", 32'(bus.memCe_n), 32'(1));
      checkOutput("reset memOe_n", 32'(bus.memOe_n), 32'(1));
      checkOutput("reset memWe_n", 32'(bus.memWe_n), 32'(1));
      checkOutput("reset memDataOe", 32'(bus.memDataOe), 32'(0));
      checkOutput("reset memAddr", 32'(bus.memAddr), 32'(0));
      checkOutput("reset vidValid", 32'(bus.vidValid), 32'(0));
      checkOutput("reset cpuAck", 32'(bus.cpuAck), 32'(0));
      checkOutput("reset cpuStarved", 32'(bus.cpuStarved), 32'(0));
      reset_n = 1'b1;

      // Video-only fetch granted in cycle 10.
      while (cyc < 10) tick();
      applyStimulus(vecs[2]);

      // Table of isolated transactions.
      for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

      // Collision: video first, CPU one cycle later, exactly one ack.
      bus.vidReq  = 1'b1;
      bus.vidAddr = 15'h0123;
      bus.cpuReq  = 1'b1;
      bus.cpuWe   = 1'b0;
      bus.cpuAddr = 15'h7FFF;
      pushVid(cyc + 2, 8'hA5);
      pushCpu(cyc + 3, 1'b1, 8'h3C);
      tick();
      bus.vidReq = 1'b0;
      checkOutput("collision vid memAddr", 32'(bus.memAddr), 32'(15'h0123));
      tick();
      checkOutput("collision cpu memAddr", 32'(bus.memAddr), 32'(15'h7FFF));
      checkOutput("collision cpu memCe_n", 32'(bus.memCe_n), 32'(0));
      waitCpuAckAndDrop();
      tick();
      tick();

      // Starvation: 800 lost cycles to back-to-back video fetches.
      bus.cpuReq  = 1'b1;
      bus.cpuWe   = 1'b0;
      bus.cpuAddr = 15'h0123;
      for (int i = 0; i < 800; i++) begin
         bus.vidReq  = 1'b1;
         bus.vidAddr = 15'h0000;
         pushVid(cyc + 2, 8'h5A);
         tick();
         if (i == 798) checkOutput("starved before limit", 32'(bus.cpuStarved), 32'(0));
      end
      checkOutput("starved at limit", 32'(bus.cpuStarved), 32'(1));
      bus.cpuStarvedClr = 1'b1;
      pushVid(cyc + 2, 8'h5A);
      tick();
      bus.cpuStarvedClr = 1'b0;
      checkOutput("starved clear vs set", 32'(bus.cpuStarved), 32'(1));
      bus.vidReq = 1'b0;
      pushCpu(cyc + 2, 1'b1, 8'hA5);
      tick();
      checkOutput("starved cpu served memAddr", 32'(bus.memAddr), 32'(15'h0123));
      waitCpuAckAndDrop();
      checkOutput("starved sticky", 32'(bus.cpuStarved), 32'(1));
      bus.cpuStarvedClr = 1'b1;
      tick();
      bus.cpuStarvedClr = 1'b0;
      checkOutput("starved cleared", 32'(bus.cpuStarved), 32'(0));
      tick();
      tick();

      // Reset while a CPU read is in flight; cpuReq held across reset.
      bus.cpuReq  = 1'b1;
      bus.cpuWe   = 1'b0;
      bus.cpuAddr = 15'h7FFF;
      tick();
      checkOutput("abort access started", 32'(bus.memCe_n), 32'(0));
      reset_n = 1'b0;
      #1;
      checkOutput("abort memCe_n", 32'(bus.memCe_n), 32'(1));
      checkOutput("abort memOe_n", 32'(bus.memOe_n), 32'(1));
      checkOutput("abort memWe_n", 32'(bus.memWe_n), 32'(1));
      checkOutput("abort memDataOe", 32'(bus.memDataOe), 32'(0));
      checkOutput("abort memAddr", 32'(bus.memAddr), 32'(0));
      checkOutput("abort memWData", 32'(bus.memWData), 32'(0));
      checkOutput("abort vidData", 32'(bus.vidData), 32'(0));
      checkOutput("abort cpuRData", 32'(bus.cpuRData), 32'(0));
      tick();
      checkOutput("abort no cpuAck", 32'(bus.cpuAck), 32'(0));
      tick();
      checkOutput("abort still no cpuAck", 32'(bus.cpuAck), 32'(0));
      reset_n = 1'b1;
      pushCpu(cyc + 2, 1'b1, 8'h3C);
      tick();
      waitCpuAckAndDrop();
      tick();
      tick();
      tick();

      checkOutput("scoreboard vid drained", 32'(vidQ.size()), 32'(0));
      checkOutput("scoreboard cpu drained", 32'(cpuQ.size()), 32'(0));
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Shares one asynchronous video SRAM between two requesters.
  - Video scanout fetch: time-critical, fixed latency, never stalled.
  - CPU/drawing port: req/ack handshake; reads and writes.
- Sits between the VGA timing/scanout logic and the external SRAM pins, all on the pixel clock.
- Strict video priority. The CPU gets every cycle the scanout does not request, mostly during blanking. A wait counter flags CPU starvation.

Parameters:
ADDR_W, 15, SRAM address width
DATA_W, 8, SRAM data width
MAX_WAIT, 10'd800, CPU wait cycles (one scan line) before cpuStarved sets

Ports:
vgaClock  in  1  pixel clock; all logic on posedge
reset_n  in  1  reset, asynchronous, active-low
vidReq  in  1  scanout read request, single-cycle pulse
vidAddr  in  ADDR_W  scanout address, valid with vidReq
vidData  out  DATA_W  scanout read data
vidValid  out  1  vidData valid, one-cycle pulse
cpuReq  in  1  CPU request level; held with cpuWe/cpuAddr/cpuWData stable until cpuAck
cpuWe  in  1  1=write, 0=read
cpuAddr  in  ADDR_W  CPU address
cpuWData  in  DATA_W  CPU write data
cpuAck  out  1  one-cycle completion pulse
cpuRData  out  DATA_W  CPU read data, valid with cpuAck on reads
cpuStarvedClr  in  1  clears cpuStarved
cpuStarved  out  1  sticky starvation flag
memAddr  out  ADDR_W  SRAM address
memWData  out  DATA_W  SRAM write data
memDataOe  out  1  top-level tristate enable for memWData
memRData  in  DATA_W  SRAM read data
memCe_n  out  1  SRAM chip enable, active-low
memOe_n  out  1  SRAM output enable, active-low
memWe_n  out  1  SRAM write enable, active-low

Behaviour:
- Reset values (async on reset_n low):
  - memCe_n=memOe_n=memWe_n=1; memDataOe=0.
  - memAddr, memWData, vidData, cpuRData = 0.
  - vidValid=0, cpuAck=0, cpuStarved=0; wait counter=0; CPU in-flight flag=0.
- Pipeline, per-cycle grant (stage 0) -> SRAM access (stage 1) -> capture (stage 2).
- Grant in cycle N, evaluated as GNT_NONE/GNT_VID/GNT_CPU_RD/GNT_CPU_WR:
  - vidReq=1 -> GNT_VID, unconditionally.
  - else cpuReq=1 and no CPU access in flight -> GNT_CPU_RD or GNT_CPU_WR per cpuWe.
  - else GNT_NONE.
- Cycle N+1, registered outputs:
  - GNT_VID / GNT_CPU_RD: memAddr=addr, memCe_n=0, memOe_n=0, memWe_n=1, memDataOe=0.
  - GNT_CPU_WR: memAddr=cpuAddr, memWData=cpuWData, memCe_n=0, memOe_n=1, memWe_n=0, memDataOe=1.
  - GNT_NONE: strobes deasserted; memAddr holds its last value.
- Cycle N+2:
  - Video: vidData=memRData sampled at end of N+1; vidValid=1.
  - CPU: cpuAck=1; on reads cpuRData=memRData.
  - Video latency is fixed at exactly 2 cycles, never stretched.
- CPU in-flight flag:
  - Set on CPU grant, cleared in the cpuAck cycle.
  - No second CPU grant until cleared, so at most 1 CPU access outstanding and at most 1 ack per request.
  - The requester drops cpuReq or presents the next request in the cycle after cpuAck. A cpuReq still high then is treated as a new request.
- Back-to-back video requests on consecutive cycles are all served. CPU throughput is 1 access per 3 cycles at best.
- Wait counter:
  - Increments each cycle cpuReq=1 with no in-flight access and no CPU grant (i.e. lost to vidReq).
  - Resets to 0 on CPU grant or cpuReq=0.
  - Saturates at MAX_WAIT; reaching MAX_WAIT sets cpuStarved.
- cpuStarved is sticky. It clears only on reset or cpuStarvedClr=1. If clear and set occur in the same cycle, set wins.
- Reset mid-operation: any in-flight access is aborted, with no vidValid or cpuAck issued for it. cpuReq still high after reset release is re-arbitrated from scratch.
- Address arithmetic: none; addresses are passed through unmodified.

Decomposition:
- Package vga_mem_pkg:
  - Grant encoding: GNT_NONE=2'b00, GNT_VID=2'b01, GNT_CPU_RD=2'b10, GNT_CPU_WR=2'b11.
  - ADDR_W/DATA_W defaults, ACTIVE/INACTIVE strobe levels, MAX_WAIT default.
- One sub-module, vga_mem_wait_counter: saturating counter plus sticky starvation flag with set-priority clear.

Test Plan:
- Reset while a CPU read is in flight -> no cpuAck; memCe_n/memOe_n/memWe_n=1 and memDataOe=0 immediately; all outputs at reset values.
- Video-only: vidReq pulse at cycle 10, vidAddr=15'h0123, SRAM model returns 8'hA5 -> memAddr=15'h0123 with memOe_n=0 at cycle 11; vidValid=1, vidData=8'hA5 at cycle 12.
- CPU write then read: cpuWe=1, cpuAddr=15'h7FFF, cpuWData=8'h3C, vidReq idle -> memWe_n=0 for 1 cycle, cpuAck 2 cycles after grant. A following read of 15'h7FFF -> cpuAck with cpuRData=8'h3C.
- Collision: vidReq and cpuReq both high at cycle 20 -> video granted at 20 (vidValid at 22), CPU granted at 21, cpuAck at 23. Exactly one cpuAck.
- Starvation: cpuReq held while vidReq is high every cycle for 800 cycles -> cpuStarved=1 at cycle 800; drop vidReq -> CPU served. Pulse cpuStarvedClr -> cpuStarved=0. Clear coincident with a set -> flag stays 1.
